// File: rtl/rsa_job_scheduler.sv
// Two-requester front end for a shared RSA control core: round-robin grant, inverter and
// mod-exp start sequencing with guard cycles, a watchdog per wait phase, and a held response.
module rsa_job_scheduler #(
  parameter int WIDTH   = 128,
  parameter int TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_p,
  input  logic [2*WIDTH-1:0]   req_q,
  input  logic [1:0]           req_encrypt_decrypt,
  input  logic [4*WIDTH-1:0]   req_msg,
  output logic [WIDTH-1:0]     core_p,
  output logic [WIDTH-1:0]     core_q,
  output logic                 core_encrypt_decrypt,
  output logic [2*WIDTH-1:0]   core_msg_in,
  output logic                 core_reset_inverter,
  output logic                 core_reset_mod_exp,
  input  logic                 core_inverter_finish,
  input  logic                 core_mod_exp_finish,
  input  logic [2*WIDTH-1:0]   core_msg_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_msg,
  output logic                 rsp_timeout,
  output logic                 busy
);

  localparam int WD_W = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INV_START = 3'd1,
    S_INV_GUARD = 3'd2,
    S_INV_WAIT  = 3'd3,
    S_EXP_START = 3'd4,
    S_EXP_GUARD = 3'd5,
    S_EXP_WAIT  = 3'd6,
    S_RESP      = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic [WIDTH-1:0]    core_p_q, core_p_d;
  logic [WIDTH-1:0]    core_q_q, core_q_d;
  logic                core_ed_q, core_ed_d;
  logic [2*WIDTH-1:0]  core_msg_q, core_msg_d;
  logic                inv_pulse_q, inv_pulse_d;
  logic                exp_pulse_q, exp_pulse_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0]  rsp_msg_q, rsp_msg_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                busy_q, busy_d;
  logic [1:0]          gnt_s;
  logic                gnt_id_s;

  // Grant decode: only in IDLE; on contention the requester not served last wins.
  always_comb begin
    gnt_s    = 2'b00;
    gnt_id_s = 1'b0;
    if (state_q == S_IDLE) begin
      if (req_valid == 2'b11) begin
        gnt_id_s = ~last_grant_q;
        gnt_s    = last_grant_q ? 2'b01 : 2'b10;
      end else if (req_valid[0]) begin
        gnt_id_s = 1'b0;
        gnt_s    = 2'b01;
      end else if (req_valid[1]) begin
        gnt_id_s = 1'b1;
        gnt_s    = 2'b10;
      end else begin
        gnt_s    = 2'b00;
      end
    end else begin
      gnt_s = 2'b00;
    end
  end

  // Accept strobe must be combinational to land in the grant cycle; masked while in reset.
  assign req_ready = gnt_s & {2{reset_n}};

  // Next-state, operand latching, watchdog and response capture.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    wdog_d        = wdog_q;
    core_p_d      = core_p_q;
    core_q_d      = core_q_q;
    core_ed_d     = core_ed_q;
    core_msg_d    = core_msg_q;
    rsp_id_d      = rsp_id_q;
    rsp_msg_d     = rsp_msg_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_s != 2'b00) begin
          state_d      = S_INV_START;
          last_grant_d = gnt_id_s;
          rsp_id_d     = gnt_id_s;
          core_p_d     = gnt_id_s ? req_p[2*WIDTH-1:WIDTH] : req_p[WIDTH-1:0];
          core_q_d     = gnt_id_s ? req_q[2*WIDTH-1:WIDTH] : req_q[WIDTH-1:0];
          core_ed_d    = gnt_id_s ? req_encrypt_decrypt[1] : req_encrypt_decrypt[0];
          core_msg_d   = gnt_id_s ? req_msg[4*WIDTH-1:2*WIDTH] : req_msg[2*WIDTH-1:0];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INV_START: state_d = S_INV_GUARD;
      S_INV_GUARD: begin
        state_d = S_INV_WAIT;
        wdog_d  = '0;
      end
      S_INV_WAIT: begin
        if (core_inverter_finish) begin
          state_d = S_EXP_START;
        end else if (wdog_q == WD_LAST) begin
          state_d       = S_RESP;
          rsp_msg_d     = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + {{(WD_W-1){1'b0}}, 1'b1};
        end
      end
      S_EXP_START: state_d = S_EXP_GUARD;
      S_EXP_GUARD: begin
        state_d = S_EXP_WAIT;
        wdog_d  = '0;
      end
      S_EXP_WAIT: begin
        if (core_mod_exp_finish) begin
          state_d       = S_RESP;
          rsp_msg_d     = core_msg_out;
          rsp_timeout_d = 1'b0;
        end else if (wdog_q == WD_LAST) begin
          state_d       = S_RESP;
          rsp_msg_d     = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + {{(WD_W-1){1'b0}}, 1'b1};
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    inv_pulse_d = (state_d == S_INV_START);
    exp_pulse_d = (state_d == S_EXP_START);
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers; last_grant resets to 1 so requester 0 wins first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      wdog_q        <= '0;
      core_p_q      <= '0;
      core_q_q      <= '0;
      core_ed_q     <= 1'b0;
      core_msg_q    <= '0;
      inv_pulse_q   <= 1'b0;
      exp_pulse_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_msg_q     <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      wdog_q        <= wdog_d;
      core_p_q      <= core_p_d;
      core_q_q      <= core_q_d;
      core_ed_q     <= core_ed_d;
      core_msg_q    <= core_msg_d;
      inv_pulse_q   <= inv_pulse_d;
      exp_pulse_q   <= exp_pulse_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_msg_q     <= rsp_msg_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign core_p               = core_p_q;
  assign core_q               = core_q_q;
  assign core_encrypt_decrypt = core_ed_q;
  assign core_msg_in          = core_msg_q;
  assign core_reset_inverter  = inv_pulse_q;
  assign core_reset_mod_exp   = exp_pulse_q;
  assign rsp_valid            = rsp_valid_q;
  assign rsp_id               = rsp_id_q;
  assign rsp_msg              = rsp_msg_q;
  assign rsp_timeout          = rsp_timeout_q;
  assign busy                 = busy_q;

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Directed bench for rsa_job_scheduler: a delay-programmable core model, a job table with
// hand-computed results and latencies, plus hand sequences for reset behaviour.
module tb_rsa_job_scheduler;

  localparam int W = 128;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_p, req_q;
  logic [1:0]     req_encrypt_decrypt;
  logic [4*W-1:0] req_msg;
  logic [W-1:0]   core_p, core_q;
  logic           core_encrypt_decrypt;
  logic [2*W-1:0] core_msg_in;
  logic           core_reset_inverter, core_reset_mod_exp;
  logic           core_inverter_finish, core_mod_exp_finish;
  logic [2*W-1:0] core_msg_out;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_timeout, busy;
  logic [2*W-1:0] rsp_msg;

  rsa_job_scheduler #(.WIDTH(W), .TIMEOUT(100)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_p(req_p), .req_q(req_q),
    .req_encrypt_decrypt(req_encrypt_decrypt), .req_msg(req_msg),
    .core_p(core_p), .core_q(core_q),
    .core_encrypt_decrypt(core_encrypt_decrypt), .core_msg_in(core_msg_in),
    .core_reset_inverter(core_reset_inverter), .core_reset_mod_exp(core_reset_mod_exp),
    .core_inverter_finish(core_inverter_finish), .core_mod_exp_finish(core_mod_exp_finish),
    .core_msg_out(core_msg_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_msg(rsp_msg), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Core model: finish levels rise a programmable number of cycles after each start pulse;
  // result = msg + p + q + mode.
  int       cyc = 0;
  int       inv_dly = 0, exp_dly = 0, inv_cnt = 0, exp_cnt = 0;
  bit       inv_stuck = 1'b0;
  logic     inv_fin_r = 1'b0, exp_fin_r = 1'b0;
  int       inv_pulses = 0, exp_pulses = 0, inv_cyc = 0, exp_cyc = 0, dual_cnt = 0;
  logic [2*W-1:0] msg_out_r = '0;

  assign core_inverter_finish = inv_fin_r | inv_stuck;
  assign core_mod_exp_finish  = exp_fin_r;
  assign core_msg_out         = msg_out_r;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_reset_inverter) begin
      inv_fin_r <= 1'b0; inv_cnt <= inv_dly; inv_pulses <= inv_pulses + 1; inv_cyc <= cyc;
    end else if (inv_cnt == 1) begin
      inv_fin_r <= 1'b1; inv_cnt <= 0;
    end else if (inv_cnt != 0) begin
      inv_cnt <= inv_cnt - 1;
    end
    if (core_reset_mod_exp) begin
      exp_fin_r <= 1'b0; exp_cnt <= exp_dly; exp_pulses <= exp_pulses + 1; exp_cyc <= cyc;
    end else if (exp_cnt == 1) begin
      exp_fin_r <= 1'b1; exp_cnt <= 0;
      msg_out_r <= core_msg_in + {{W{1'b0}}, core_p} + {{W{1'b0}}, core_q}
                   + {{(2*W-1){1'b0}}, core_encrypt_decrypt};
    end else if (exp_cnt != 0) begin
      exp_cnt <= exp_cnt - 1;
    end
    if (core_reset_inverter && core_reset_mod_exp) dual_cnt <= dual_cnt + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]     mask;
    logic [W-1:0]   p0, q0, p1, q1;
    logic [1:0]     mode;
    logic [2*W-1:0] msg0, msg1;
    int             inv_dly, exp_dly;
    bit             stuck;
    int             hold;
    logic [1:0]     exp_ready;
    logic [2*W-1:0] exp_msg;
    logic           exp_to;
    int             exp_np, exp_off, rsp_off;
  } vec_t;

  vec_t vecs[8];

  task automatic run_job(input vec_t v);
    int ip, ep, t0, k;
    bit seen;
    ip = inv_pulses; ep = exp_pulses;
    inv_dly = v.inv_dly; exp_dly = v.exp_dly; inv_stuck = v.stuck;
    @(negedge clk);
    req_valid = v.mask;
    req_p = {v.p1, v.p0}; req_q = {v.q1, v.q0};
    req_encrypt_decrypt = v.mode; req_msg = {v.msg1, v.msg0};
    #1;
    t0 = cyc;
    chk("grant", 256'(req_ready), 256'(v.exp_ready));
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("inv_pulse_t1", 256'(core_reset_inverter), 256'd1);
    chk("core_p", 256'(core_p), 256'(v.exp_ready[1] ? v.p1 : v.p0));
    chk("core_msg_in", core_msg_in, v.exp_ready[1] ? v.msg1 : v.msg0);
    chk("core_mode", 256'(core_encrypt_decrypt), 256'(v.exp_ready[1] ? v.mode[1] : v.mode[0]));
    seen = 1'b0;
    for (k = 0; k < 300 && !seen; k++) begin
      @(negedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("rsp_seen", 256'(seen), 256'd1);
    chk("rsp_latency", 256'(cyc - t0), 256'(v.rsp_off));
    chk("rsp_id", 256'(rsp_id), 256'(v.exp_ready[1]));
    chk("rsp_msg", rsp_msg, v.exp_msg);
    chk("rsp_timeout", 256'(rsp_timeout), 256'(v.exp_to));
    chk("inv_pulse_cnt", 256'(inv_pulses - ip), 256'd1);
    chk("exp_pulse_cnt", 256'(exp_pulses - ep), 256'(v.exp_np));
    if (v.exp_np == 1) chk("exp_pulse_off", 256'(exp_cyc - t0), 256'(v.exp_off));
    req_valid = 2'b11;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk); #1;
      chk("hold_valid", 256'(rsp_valid), 256'd1);
      chk("hold_msg", rsp_msg, v.exp_msg);
      chk("hold_id", 256'(rsp_id), 256'(v.exp_ready[1]));
      chk("hold_ready", 256'(req_ready), 256'd0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("post_hs_idle", 256'({rsp_valid, busy}), 256'd0);
  endtask

  initial begin
    int ep0;
    int stray;
    vecs[0] = '{mask:2'b01, p0:128'd113680897410347, q0:128'd7999808077935876437321,
                p1:128'd0, q1:128'd0, mode:2'b00, msg0:256'd1000, msg1:256'd0,
                inv_dly:5, exp_dly:20, stuck:1'b0, hold:0, exp_ready:2'b01,
                exp_msg:256'd7999808191616773848668, exp_to:1'b0, exp_np:1, exp_off:8, rsp_off:30};
    vecs[1] = '{mask:2'b10, p0:128'd0, q0:128'd0, p1:128'd7, q1:128'd11, mode:2'b10,
                msg0:256'd0, msg1:256'h100, inv_dly:2, exp_dly:4, stuck:1'b0, hold:0,
                exp_ready:2'b10, exp_msg:256'd275, exp_to:1'b0, exp_np:1, exp_off:5, rsp_off:11};
    vecs[2] = '{mask:2'b11, p0:128'd3, q0:128'd5, p1:128'd100, q1:128'd200, mode:2'b10,
                msg0:256'd10, msg1:256'd1, inv_dly:1, exp_dly:1, stuck:1'b0, hold:0,
                exp_ready:2'b01, exp_msg:256'd18, exp_to:1'b0, exp_np:1, exp_off:4, rsp_off:7};
    vecs[3] = '{mask:2'b11, p0:128'd3, q0:128'd5, p1:128'd100, q1:128'd200, mode:2'b10,
                msg0:256'd10, msg1:256'd1, inv_dly:3, exp_dly:2, stuck:1'b0, hold:10,
                exp_ready:2'b10, exp_msg:256'd302, exp_to:1'b0, exp_np:1, exp_off:6, rsp_off:10};
    vecs[4] = '{mask:2'b11, p0:128'd1, q0:128'd2, p1:128'd100, q1:128'd200, mode:2'b01,
                msg0:256'd1000, msg1:256'd1, inv_dly:0, exp_dly:3, stuck:1'b1, hold:0,
                exp_ready:2'b01, exp_msg:256'd1004, exp_to:1'b0, exp_np:1, exp_off:4, rsp_off:9};
    vecs[5] = '{mask:2'b10, p0:128'd0, q0:128'd0, p1:128'd9, q1:128'd9, mode:2'b00,
                msg0:256'd0, msg1:256'd77, inv_dly:0, exp_dly:5, stuck:1'b0, hold:0,
                exp_ready:2'b10, exp_msg:256'd0, exp_to:1'b1, exp_np:0, exp_off:0, rsp_off:103};
    vecs[6] = '{mask:2'b11, p0:128'd2, q0:128'd2, p1:128'd4, q1:128'd4, mode:2'b10,
                msg0:256'd2, msg1:256'd4, inv_dly:1, exp_dly:1, stuck:1'b0, hold:0,
                exp_ready:2'b01, exp_msg:256'd6, exp_to:1'b0, exp_np:1, exp_off:4, rsp_off:7};
    vecs[7] = '{mask:2'b11, p0:128'd2, q0:128'd2, p1:128'd4, q1:128'd4, mode:2'b10,
                msg0:256'd2, msg1:256'd4, inv_dly:2, exp_dly:2, stuck:1'b0, hold:0,
                exp_ready:2'b10, exp_msg:256'd13, exp_to:1'b0, exp_np:1, exp_off:5, rsp_off:9};

    reset_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
    req_p = '0; req_q = '0; req_encrypt_decrypt = 2'b00; req_msg = '0;
    #23;
    chk("rst_ctrl", 256'({req_ready, busy, rsp_valid, rsp_id, rsp_timeout,
                          core_reset_inverter, core_reset_mod_exp}), 256'd0);
    chk("rst_rsp_msg", rsp_msg, 256'd0);
    @(negedge clk);
    reset_n = 1'b1; req_valid = 2'b00;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_job(vecs[i]);

    // Reset asserted while the job sits in EXP_WAIT.
    inv_dly = 2; exp_dly = 50; inv_stuck = 1'b0;
    ep0 = exp_pulses;
    @(negedge clk);
    req_valid = 2'b10; req_p = {128'd21, 128'd0}; req_q = {128'd22, 128'd0};
    req_msg = {256'd23, 256'd0}; req_encrypt_decrypt = 2'b10;
    #1;
    chk("mid_grant", 256'(req_ready), 256'd2);
    @(negedge clk);
    req_valid = 2'b00;
    for (int k = 0; k < 50 && exp_pulses == ep0; k++) @(negedge clk);
    chk("mid_exp_started", 256'(exp_pulses - ep0), 256'd1);
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0; req_valid = 2'b11;
    #1;
    chk("async_rst_ctrl", 256'({req_ready, busy, rsp_valid, rsp_id, rsp_timeout,
                                core_reset_inverter, core_reset_mod_exp, core_encrypt_decrypt}), 256'd0);
    chk("async_rst_core_p", 256'(core_p), 256'd0);
    chk("async_rst_core_msg", core_msg_in, 256'd0);
    @(negedge clk);
    reset_n = 1'b1; req_valid = 2'b00;
    stray = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (rsp_valid || busy) stray++;
    end
    chk("no_rsp_after_reset", 256'(stray), 256'd0);

    for (int i = 6; i < 8; i++) run_job(vecs[i]);

    chk("no_dual_pulse", 256'(dual_cnt), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/rsa_job_scheduler.md
RSA_JOB_SCHEDULER -- requirements
Module: rsa_job_scheduler

Interface
REQ-001 Parameter WIDTH, default 128, prime operand width; message width is 2*WIDTH.
REQ-002 Parameter TIMEOUT, default 65535, maximum cycles allowed in any finish-wait state.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester job request; bit i = requester i.
REQ-006 req_ready  output  2  per-requester accept strobe.
REQ-007 req_p  input  2*WIDTH  packed p operands; requester i at [i*WIDTH +: WIDTH].
REQ-008 req_q  input  2*WIDTH  packed q operands, same packing.
REQ-009 req_encrypt_decrypt  input  2  per-requester mode bit.
REQ-010 req_msg  input  4*WIDTH  packed messages; requester i at [i*2*WIDTH +: 2*WIDTH].
REQ-011 core_p, core_q  output  WIDTH each  operands to shared control core.
REQ-012 core_encrypt_decrypt  output  1  mode to core.
REQ-013 core_msg_in  output  2*WIDTH  message to core.
REQ-014 core_reset_inverter  output  1  inverter start pulse.
REQ-015 core_reset_mod_exp  output  1  mod-exp start pulse.
REQ-016 core_inverter_finish, core_mod_exp_finish  input  1 each  core completion levels.
REQ-017 core_msg_out  input  2*WIDTH  core result.
REQ-018 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-019 rsp_id  output  1  requester index of the response.
REQ-020 rsp_msg  output  2*WIDTH  result data.
REQ-021 rsp_timeout  output  1  job aborted by watchdog.
REQ-022 busy  output  1  high in any state other than IDLE.

Function
REQ-023 FSM states: IDLE, INV_START, INV_GUARD, INV_WAIT, EXP_START, EXP_GUARD, EXP_WAIT, RESP.
REQ-024 IDLE: if any req_valid bit is set, grant one, pulse its req_ready bit for exactly that cycle, latch its p/q/mode/msg into core_* registers, go to INV_START.
REQ-025 Arbitration: round-robin; with both valid, grant the requester not granted last; last_grant updates on every grant.
REQ-026 core_* operand outputs SHALL remain stable from the cycle after the grant until the next grant.
REQ-027 INV_START: core_reset_inverter=1 for exactly one cycle; then INV_GUARD for one cycle (finish ignored); then INV_WAIT.
REQ-028 INV_WAIT: core_inverter_finish=1 -> EXP_START; same pattern for EXP_START/EXP_GUARD/EXP_WAIT using core_reset_mod_exp and core_mod_exp_finish.
REQ-029 EXP_WAIT: on core_mod_exp_finish=1, capture core_msg_out into rsp_msg, set rsp_timeout=0, enter RESP.
REQ-030 Watchdog: a 16-bit-or-wider counter clears on entry to each WAIT state and increments each WAIT cycle; reaching TIMEOUT enters RESP with rsp_msg=0 and rsp_timeout=1.
REQ-031 RESP: rsp_valid=1; rsp_id, rsp_msg and rsp_timeout stable until rsp_ready=1; handshake cycle -> IDLE.
REQ-032 No grant SHALL occur outside IDLE; req_ready is 0 in every other state.
REQ-033 Start pulses are never asserted simultaneously; each start pulse occurs exactly once per job.
REQ-034 Latency: grant cycle T; inverter pulse T+1; finish is first sampled at T+3.

Reset
REQ-035 reset_n low SHALL immediately force IDLE; all outputs 0; watchdog 0; last_grant=1, so requester 0 wins the first contention.
REQ-036 reset_n asserted mid-job SHALL abort the job with no response; the requester must re-request.

Verification
REQ-037 Single req0 (p=113680897410347, q=7999808077935876437321, mode 0); core model finish at +5/+20 cycles -> one-cycle pulses at T+1 and at the EXP_START cycle; rsp_id=0; rsp_msg equals model output; rsp_timeout=0.
REQ-038 Both req_valid asserted together after reset -> requester 0 served first, then requester 1; repeated contention alternates.
REQ-039 rsp_ready held low for 10 cycles in RESP -> rsp_valid, rsp_msg and rsp_id unchanged; req_ready stays 00.
REQ-040 TIMEOUT=100 and inverter_finish never rises -> RESP entered after 100 INV_WAIT cycles with rsp_timeout=1 and rsp_msg=0; core_reset_mod_exp never pulsed.
REQ-041 core_inverter_finish stuck high from the previous job -> ignored during INV_GUARD; advance occurs at the first INV_WAIT cycle only.
REQ-042 reset_n pulsed low during EXP_WAIT -> all outputs 0 asynchronously; no rsp_valid; next grant goes to requester 0.
